// File: rtl/frame_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : frame_buffer
// Purpose  : Collects filter samples into overlapping frames (FRAME_LEN long,
//            one every HOP samples) and streams each frame oldest-first.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buffer #(
   parameter int FRAME_LEN = 64,
   parameter int HOP       = 32,
   parameter int BW        = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          en_i,
   input  logic [BW-1:0] data_i,
   input  logic          valid_i,
   output logic [BW-1:0] data_o,
   output logic          valid_o,
   input  logic          ready_i,
   output logic          last_o,
   output logic          overflow_o
);

   localparam int c_depth = FRAME_LEN + HOP;
   localparam int c_aw    = (c_depth > 1) ? $clog2(c_depth) : 1;
   localparam int c_fw    = $clog2(FRAME_LEN);
   localparam int c_hw    = (HOP > 1) ? $clog2(HOP) : 1;

   localparam logic [c_aw:0]   c_hop_inc   = (c_aw+1)'(HOP);
   localparam logic [c_aw:0]   c_one_inc   = (c_aw+1)'(1);
   localparam logic [c_fw-1:0] c_beat_last = c_fw'(FRAME_LEN-1);
   localparam logic [c_fw-1:0] c_beat_pen  = c_fw'(FRAME_LEN-2);
   localparam logic [c_hw-1:0] c_hop_last  = c_hw'(HOP-1);

   localparam logic [1:0] c_prime = 2'd0;
   localparam logic [1:0] c_idle  = 2'd1;
   localparam logic [1:0] c_fetch = 2'd2;
   localparam logic [1:0] c_emit  = 2'd3;

   logic [BW-1:0]   r_ram [c_depth];
   logic [1:0]      r_state;
   logic [c_aw-1:0] r_wr_ptr;
   logic [c_aw-1:0] r_base;
   logic [c_aw-1:0] r_rd_addr;
   logic [c_fw-1:0] r_prime_cnt;
   logic [c_fw-1:0] r_beat;
   logic [c_hw-1:0] r_hop_cnt;
   logic [BW-1:0]   r_data;
   logic            r_valid;
   logic            r_last;
   logic            r_overflow;

   logic            w_wr;
   logic            w_hs;
   logic [c_aw-1:0] w_base_nxt;

   // Modular add for pointers; DEPTH need not be a power of two.
   function automatic logic [c_aw-1:0] f_add_mod(input logic [c_aw-1:0] a,
                                                 input logic [c_aw:0]   b);
      logic [c_aw:0] s;
      s = {1'b0, a} + b;
      if (s >= (c_aw+1)'(c_depth))
         s = s - (c_aw+1)'(c_depth);
      return s[c_aw-1:0];
   endfunction

   assign w_wr       = en_i & valid_i;
   assign w_hs       = r_valid & ready_i;
   assign w_base_nxt = f_add_mod(r_base, c_hop_inc);

   always_ff @(posedge clk_i) begin
      if (w_wr)
         r_ram[r_wr_ptr] <= data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= c_prime;
         r_wr_ptr    <= '0;
         r_base      <= '0;
         r_rd_addr   <= '0;
         r_prime_cnt <= '0;
         r_beat      <= '0;
         r_hop_cnt   <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_last      <= 1'b0;
         r_overflow  <= 1'b0;
      end else if (!en_i) begin
         r_state     <= c_prime;
         r_wr_ptr    <= '0;
         r_base      <= '0;
         r_rd_addr   <= '0;
         r_prime_cnt <= '0;
         r_beat      <= '0;
         r_hop_cnt   <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_last      <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_wr)
            r_wr_ptr <= f_add_mod(r_wr_ptr, c_one_inc);

         case (r_state)
            c_prime: begin
               if (w_wr) begin
                  if (r_prime_cnt == c_beat_last) begin
                     r_prime_cnt <= '0;
                     r_rd_addr   <= r_base;
                     r_state     <= c_fetch;
                  end else begin
                     r_prime_cnt <= r_prime_cnt + c_fw'(1);
                  end
               end
            end
            c_idle: begin
            end
            c_fetch: begin
               r_data    <= r_ram[r_rd_addr];
               r_rd_addr <= f_add_mod(r_rd_addr, c_one_inc);
               r_beat    <= '0;
               r_valid   <= 1'b1;
               r_last    <= 1'b0;
               r_state   <= c_emit;
            end
            c_emit: begin
               if (w_hs) begin
                  if (r_beat == c_beat_last) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_state <= c_idle;
                  end else begin
                     // rd_addr already points one ahead, so the next beat is ready now.
                     r_data    <= r_ram[r_rd_addr];
                     r_rd_addr <= f_add_mod(r_rd_addr, c_one_inc);
                     r_beat    <= r_beat + c_fw'(1);
                     r_last    <= (r_beat == c_beat_pen);
                  end
               end
            end
            default: r_state <= c_prime;
         endcase

         // A frame due outside IDLE is dropped, but the base still moves on.
         if (w_wr && (r_state != c_prime)) begin
            if (r_hop_cnt == c_hop_last) begin
               r_hop_cnt <= '0;
               r_base    <= w_base_nxt;
               if (r_state == c_idle) begin
                  r_rd_addr <= w_base_nxt;
                  r_state   <= c_fetch;
               end else begin
                  r_overflow <= 1'b1;
               end
            end else begin
               r_hop_cnt <= r_hop_cnt + c_hw'(1);
            end
         end
      end
   end

   assign data_o     = r_data;
   assign valid_o    = r_valid;
   assign last_o     = r_last;
   assign overflow_o = r_overflow;

endmodule
`default_nettype wire
